// File: rtl/grid_pkg.sv
// Shared types and constants for the 16x16 object-grid update path.
package grid_pkg;

    localparam int GRID_BITS = 4;
    localparam int OBJ_BITS  = 3;

    typedef logic [OBJ_BITS-1:0]    obj_code_t;
    typedef logic [2*GRID_BITS-1:0] cell_idx_t;

    localparam obj_code_t OBJ_BG = '0;

    typedef enum logic [1:0] {
        INIT,
        SCAN,
        ISSUE
    } sched_state_t;

endpackage

// File: rtl/dirty_tracker.sv
// One dirty bit per grid cell; a set in the same cycle as a clear of the same cell wins.
module dirty_tracker #(
    parameter int IDX_BITS = 8,
    parameter int CELLS    = 1 << IDX_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en,
    input  logic [IDX_BITS-1:0] set_idx,
    input  logic                clr_en,
    input  logic [IDX_BITS-1:0] clr_idx,
    input  logic                set_all,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic                rd_dirty,
    output logic                any_dirty
);

    logic [CELLS-1:0] dirty_q;
    logic [CELLS-1:0] set_mask;
    logic [CELLS-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_all) set_mask = '1;
        if (set_en)  set_mask[set_idx] = 1'b1;
        if (clr_en)  clr_mask[clr_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) dirty_q <= '0;
        else     dirty_q <= (dirty_q & ~clr_mask) | set_mask;
    end

    assign rd_dirty  = dirty_q[rd_idx];
    assign any_dirty = |dirty_q;

endmodule

// File: rtl/update_scheduler.sv
// Shadow map of cell object codes; sequences display init, then one draw per dirty cell.
module update_scheduler #(
    parameter int GRID_BITS = 4,
    parameter int OBJ_BITS  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic [GRID_BITS-1:0] req_x,
    input  logic [GRID_BITS-1:0] req_y,
    input  logic [OBJ_BITS-1:0]  req_obj,
    input  logic                 redraw_all,
    input  logic                 cmd_done,
    output logic                 init_cycle,
    output logic                 en_update,
    output logic [GRID_BITS-1:0] x,
    output logic [GRID_BITS-1:0] y,
    output logic [OBJ_BITS-1:0]  obj_code,
    output logic                 init_done,
    output logic                 busy
);

    import grid_pkg::*;

    localparam int IDX_BITS = 2 * GRID_BITS;
    localparam int CELLS    = 1 << IDX_BITS;

    logic [OBJ_BITS-1:0] map_q [CELLS];
    logic [IDX_BITS-1:0] ptr_q;
    logic [IDX_BITS-1:0] wr_idx;
    logic                ptr_dirty;
    logic                any_dirty;
    logic                launch;
    sched_state_t        state;

    assign wr_idx = {req_y, req_x};
    assign launch = (state == SCAN) && ptr_dirty;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CELLS; i++) map_q[i] <= OBJ_BITS'(OBJ_BG);
        end else if (req_valid) begin
            map_q[wr_idx] <= req_obj;
        end
    end

    dirty_tracker #(
        .IDX_BITS (IDX_BITS),
        .CELLS    (CELLS)
    ) u_dirty (
        .clk       (clk),
        .rst       (rst),
        .set_en    (req_valid),
        .set_idx   (wr_idx),
        .clr_en    (launch),
        .clr_idx   (ptr_q),
        .set_all   (redraw_all),
        .rd_idx    (ptr_q),
        .rd_dirty  (ptr_dirty),
        .any_dirty (any_dirty)
    );

    // init_cycle / en_update are the request valids; cmd_done is the one-cycle
    // acknowledge. A request holds with stable x/y/obj_code until cmd_done is
    // sampled high, and drops on that same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= INIT;
            ptr_q      <= '0;
            init_cycle <= 1'b0;
            init_done  <= 1'b0;
            en_update  <= 1'b0;
            x          <= '0;
            y          <= '0;
            obj_code   <= '0;
        end else begin
            case (state)
                INIT: begin
                    if (cmd_done) begin
                        init_cycle <= 1'b0;
                        init_done  <= 1'b1;
                        state      <= SCAN;
                    end else begin
                        init_cycle <= 1'b1;
                    end
                end
                SCAN: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_dirty) begin
                        x         <= ptr_q[GRID_BITS-1:0];
                        y         <= ptr_q[IDX_BITS-1:GRID_BITS];
                        obj_code  <= map_q[ptr_q];
                        en_update <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cmd_done) begin
                        en_update <= 1'b0;
                        state     <= SCAN;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    assign busy = (state != SCAN) || any_dirty;

endmodule

// File: tb/tb_update_scheduler.sv
// Randomised and directed check of update_scheduler against a cycle-level grid model.
module tb_update_scheduler;

    logic       tb_clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [3:0] req_x = '0;
    logic [3:0] req_y = '0;
    logic [2:0] req_obj = '0;
    logic       redraw_all = 1'b0;
    logic       cmd_done = 1'b0;
    logic       init_cycle, en_update, init_done, busy;
    logic [3:0] x, y;
    logic [2:0] obj_code;

    always #5 tb_clk = ~tb_clk;

    update_scheduler dut (
        .clk        (tb_clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_obj    (req_obj),
        .redraw_all (redraw_all),
        .cmd_done   (cmd_done),
        .init_cycle (init_cycle),
        .en_update  (en_update),
        .x          (x),
        .y          (y),
        .obj_code   (obj_code),
        .init_done  (init_done),
        .busy       (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the grid as plain arrays, one step per clock edge.
    typedef enum {M_INIT, M_SCAN, M_ISSUE} mode_t;
    mode_t m_mode = M_INIT;
    int    m_map[256];
    bit    m_dirty[256];
    int    m_ptr = 0;
    bit    m_init_cycle = 0, m_en = 0, m_init_done = 0;
    int    m_x = 0, m_y = 0, m_obj = 0;
    bit    model_log = 0;

    // Transactions as {y, x, obj}
    logic [10:0] exp_q[$];
    logic [10:0] got_q[$];

    function automatic bit m_any();
        for (int i = 0; i < 256; i++) if (m_dirty[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        int clr;
        logic [7:0] t;
        clr = -1;
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                m_map[i] = 0;
                m_dirty[i] = 0;
            end
            m_mode = M_INIT; m_ptr = 0;
            m_init_cycle = 0; m_en = 0; m_init_done = 0;
            m_x = 0; m_y = 0; m_obj = 0;
            return;
        end
        case (m_mode)
            M_INIT: begin
                if (cmd_done) begin
                    m_init_cycle = 0; m_init_done = 1; m_mode = M_SCAN;
                end else begin
                    m_init_cycle = 1;
                end
            end
            M_SCAN: begin
                if (m_dirty[m_ptr]) begin
                    m_x = m_ptr % 16; m_y = m_ptr / 16; m_obj = m_map[m_ptr];
                    m_en = 1; m_mode = M_ISSUE; clr = m_ptr;
                    if (model_log) begin
                        t = m_ptr[7:0];
                        exp_q.push_back({t, m_obj[2:0]});
                    end
                end
                m_ptr = (m_ptr + 1) % 256;
            end
            M_ISSUE: begin
                if (cmd_done) begin
                    m_en = 0; m_mode = M_SCAN;
                end
            end
        endcase
        if (clr >= 0) m_dirty[clr] = 0;
        if (redraw_all) for (int i = 0; i < 256; i++) m_dirty[i] = 1;
        if (req_valid) begin
            m_dirty[{req_y, req_x}] = 1;
            m_map[{req_y, req_x}] = int'(req_obj);
        end
    endtask

    bit auto_resp = 0;
    bit rand_delay = 0;
    int resp_delay = 2;
    int wait_cnt = 0;
    bit prev_en = 0;

    task automatic tick();
        @(posedge tb_clk);
        model_step();
        #1;
        check_eq("init_cycle", init_cycle, m_init_cycle);
        check_eq("en_update", en_update, m_en);
        check_eq("x", x, m_x);
        check_eq("y", y, m_y);
        check_eq("obj_code", obj_code, m_obj);
        check_eq("init_done", init_done, m_init_done);
        check_eq("busy", busy, (m_mode != M_SCAN) || m_any());
        if (en_update && !prev_en) got_q.push_back({y, x, obj_code});
        prev_en = en_update;
        req_valid = 0;
        redraw_all = 0;
        if (cmd_done) begin
            cmd_done = 0;
            wait_cnt = 0;
            if (rand_delay) resp_delay = $urandom_range(0, 3);
        end else if (auto_resp && (en_update || init_cycle)) begin
            if (wait_cnt >= resp_delay) cmd_done = 1;
            else wait_cnt++;
        end
    endtask

    task automatic write_cell(input int cx, input int cy, input int obj);
        req_valid = 1;
        req_x = cx[3:0];
        req_y = cy[3:0];
        req_obj = obj[2:0];
        tick();
    endtask

    task automatic do_init();
        int k;
        auto_resp = 1;
        k = 0;
        while (!m_init_done && k < 20) begin
            tick();
            k++;
        end
        check_eq("init_reached", init_done, 1);
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int k;
        k = 0;
        while ((m_mode != M_SCAN || m_any()) && k < budget) begin
            tick();
            k++;
        end
        check_eq({tag, "_idle_in_budget"}, k < budget, 1);
        check_eq({tag, "_busy_low"}, busy, 0);
    endtask

    task automatic compare_log(input string tag);
        logic [10:0] e, g;
        check_eq({tag, "_txn_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            check_eq({tag, "_txn"}, g, e);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        int k;
        logic [7:0] idx8;

        // Reset held two cycles, then init handshake by hand
        rst = 1;
        repeat (2) tick();
        check_eq("rst_busy", busy, 1);
        check_eq("rst_en_update", en_update, 0);
        rst = 0;
        tick();
        check_eq("init_cycle_first_edge", init_cycle, 1);
        repeat (2) tick();
        cmd_done = 1;
        tick();
        check_eq("init_cycle_dropped", init_cycle, 0);
        check_eq("init_done_set", init_done, 1);
        check_eq("idle_after_init", busy, 0);

        // Single write
        auto_resp = 1;
        resp_delay = 2;
        write_cell(3, 5, 2);
        exp_q.push_back({4'd5, 4'd3, 3'd2});
        run_until_idle("single", 300);
        compare_log("single");

        // Coalescing: both writes land well before the scan reaches 0x77
        k = 0;
        while (m_ptr != 8'h80 && k < 300) begin tick(); k++; end
        check_eq("coalesce_ptr_wait", k < 300, 1);
        write_cell(7, 7, 1);
        write_cell(7, 7, 4);
        exp_q.push_back({4'd7, 4'd7, 3'd4});
        run_until_idle("coalesce", 400);
        compare_log("coalesce");

        // Rewrite of the cell currently being drawn
        resp_delay = 4;
        write_cell(2, 1, 2);
        k = 0;
        while (!(en_update && x == 4'd2 && y == 4'd1) && k < 300) begin tick(); k++; end
        check_eq("inflight_launch_seen", k < 300, 1);
        write_cell(2, 1, 6);
        exp_q.push_back({4'd1, 4'd2, 3'd2});
        exp_q.push_back({4'd1, 4'd2, 3'd6});
        run_until_idle("inflight", 600);
        compare_log("inflight");

        // redraw_all on a cleared map, raised while still in init so ptr starts at 0
        auto_resp = 0;
        rst = 1;
        cmd_done = 0;
        wait_cnt = 0;
        repeat (2) tick();
        rst = 0;
        redraw_all = 1;
        tick();
        resp_delay = 3;
        auto_resp = 1;
        for (int i = 0; i < 256; i++) begin
            idx8 = i[7:0];
            exp_q.push_back({idx8, 3'd0});
        end
        run_until_idle("redraw", 4000);
        compare_log("redraw");

        // Random traffic checked cycle by cycle and by transaction order
        model_log = 1;
        rand_delay = 1;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 1;
                req_x = 4'($urandom_range(0, 15));
                req_y = 4'($urandom_range(0, 15));
                req_obj = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 799) == 0) redraw_all = 1;
            if (!en_update && !init_cycle && !cmd_done && $urandom_range(0, 15) == 0) cmd_done = 1;
            tick();
        end
        run_until_idle("random", 4000);
        compare_log("random");
        model_log = 0;
        rand_delay = 0;

        // Reset while an update is in flight
        resp_delay = 10;
        write_cell(9, 9, 5);
        k = 0;
        while (!en_update && k < 300) begin tick(); k++; end
        check_eq("rst_issue_launch_seen", k < 300, 1);
        tick();
        got_q.delete();
        auto_resp = 0;
        rst = 1;
        cmd_done = 0;
        wait_cnt = 0;
        tick();
        check_eq("rst_drops_en_update", en_update, 0);
        check_eq("rst_clears_init_done", init_done, 0);
        rst = 0;
        tick();
        check_eq("reinit_cycle_first_edge", init_cycle, 1);
        repeat (5) tick();
        check_eq("no_update_before_init", en_update, 0);
        resp_delay = 1;
        do_init();
        repeat (300) tick();
        check_eq("interrupted_not_retried", got_q.size(), 0);
        check_eq("idle_after_reinit", busy, 0);
        got_q.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
